// File: rtl/calc_input_ctrl.sv
// calc_input_ctrl
//   Operand entry front end for a four-function calculator. It turns debounced
//   key codes into two decimal operands and an opcode, and hands them to the
//   ALU stage through a valid/ready request.
//
//   State table
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ENTER_A  | accumulating the first operand; an operator moves to ENTER_B
//   ENTER_B  | accumulating the second operand; '=' issues the request
//   REQ      | request held for the ALU stage until req_ready
//   DONE     | result shown; a digit starts a new calculation
//
//   Ports
//   clk         clock, all state updates on its rising edge
//   clear       synchronous active-high reset
//   key_code    0-9 digit, 10 '+', 11 '-', 12 '*', 13 '/', 14 '=', 15 unused, 16 none
//   op_a, op_b  operands to the ALU stage
//   opcode      00 '+', 01 '-', 10 '*', 11 '/'
//   req_valid   operands and opcode valid (high only in REQ)
//   req_ready   ALU stage accepts the request
//   disp_value  operand currently being entered
//   busy        high in REQ
module calc_input_ctrl #(
    parameter int MAX_DIGITS = 4,
    parameter int W          = 14
) (
    input  logic         clk,
    input  logic         clear,
    input  logic [4:0]   key_code,
    output logic [W-1:0] op_a,
    output logic [W-1:0] op_b,
    output logic [1:0]   opcode,
    output logic         req_valid,
    input  logic         req_ready,
    output logic [W-1:0] disp_value,
    output logic         busy
);

    localparam int CW = $clog2(MAX_DIGITS + 1);

    localparam logic [1:0] ST_ENTER_A = 2'd0;
    localparam logic [1:0] ST_ENTER_B = 2'd1;
    localparam logic [1:0] ST_REQ     = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [4:0]    KEY_NONE = 5'd16;
    localparam logic [4:0]    KEY_EQ   = 5'd14;
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_DIGITS);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]    state;
    logic [4:0]    key_prev;
    logic [CW-1:0] cnt_a;
    logic [CW-1:0] cnt_b;
    logic          b_seen;

    logic          key_evt;
    logic          is_digit;
    logic          is_oper;
    logic          is_eq;
    logic [3:0]    digit;
    logic [W-1:0]  digit_w;
    logic [1:0]    key_opcode;
    logic [W-1:0]  acc_a;
    logic [W-1:0]  acc_b;
    logic          take_a;
    logic          take_b;

    // Rising edge of "some key pressed"; code 15 (and anything above 14 that is
    // not the idle code) never produces an event.
    assign key_evt  = (key_code != KEY_NONE) && (key_prev == KEY_NONE) && (key_code <= KEY_EQ);
    assign is_digit = key_evt && (key_code < 5'd10);
    assign is_oper  = key_evt && (key_code >= 5'd10) && (key_code <= 5'd13);
    assign is_eq    = key_evt && (key_code == KEY_EQ);

    assign digit   = key_code[3:0];
    assign digit_w = W'(digit);

    // Operator keys 10..13 map to 00..11; subtracting 2 from the low two bits
    // is the same as subtracting 10 modulo 4.
    assign key_opcode = key_code[1:0] - 2'd2;

    assign acc_a = op_a * W'(10) + digit_w;
    assign acc_b = op_b * W'(10) + digit_w;

    // A digit is absorbed only below the digit limit; a zero into a zero
    // operand leaves both operand and counter untouched.
    assign take_a = (cnt_a != CNT_MAX) && !((digit == 4'd0) && (op_a == '0));
    assign take_b = (cnt_b != CNT_MAX) && !((digit == 4'd0) && (op_b == '0));

    always_ff @(posedge clk) begin
        if (clear) begin
            state    <= ST_ENTER_A;
            key_prev <= KEY_NONE;
            op_a     <= '0;
            op_b     <= '0;
            opcode   <= 2'b00;
            cnt_a    <= '0;
            cnt_b    <= '0;
            b_seen   <= 1'b0;
        end else begin
            key_prev <= key_code;
            case (state)
                ST_ENTER_A: begin
                    if (is_digit) begin
                        if (take_a) begin
                            op_a  <= acc_a;
                            cnt_a <= cnt_a + CNT_ONE;
                        end
                    end else if (is_oper) begin
                        opcode <= key_opcode;
                        op_b   <= '0;
                        cnt_b  <= '0;
                        b_seen <= 1'b0;
                        state  <= ST_ENTER_B;
                    end
                end
                ST_ENTER_B: begin
                    if (is_digit) begin
                        // b_seen tracks digit events, including leading zeros,
                        // so "0 =" is a legal second operand.
                        b_seen <= 1'b1;
                        if (take_b) begin
                            op_b  <= acc_b;
                            cnt_b <= cnt_b + CNT_ONE;
                        end
                    end else if (is_oper) begin
                        if (!b_seen) begin
                            opcode <= key_opcode;
                        end
                    end else if (is_eq && b_seen) begin
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (req_ready) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (is_digit) begin
                        op_a   <= digit_w;
                        cnt_a  <= (digit != 4'd0) ? CNT_ONE : '0;
                        op_b   <= '0;
                        cnt_b  <= '0;
                        b_seen <= 1'b0;
                        state  <= ST_ENTER_A;
                    end
                end
                default: begin
                    state <= ST_ENTER_A;
                end
            endcase
        end
    end

    // Pure decode of registered state: no path from req_ready to req_valid.
    assign req_valid  = (state == ST_REQ);
    assign busy       = (state == ST_REQ);
    assign disp_value = (state == ST_ENTER_A) ? op_a : op_b;

endmodule

// File: tb/tb_calc_input_ctrl.sv
module tb_calc_input_ctrl;

    localparam int MAXD  = 4;
    localparam int WB    = 14;
    localparam int LIMIT = 10 ** (MAXD - 1);

    localparam int M_A    = 0;
    localparam int M_B    = 1;
    localparam int M_REQ  = 2;
    localparam int M_DONE = 3;

    logic          clk = 1'b0;
    logic          clear;
    logic [4:0]    key_code;
    logic [WB-1:0] op_a;
    logic [WB-1:0] op_b;
    logic [1:0]    opcode;
    logic          req_valid;
    logic          req_ready;
    logic [WB-1:0] disp_value;
    logic          busy;

    int vectors     = 0;
    int miscompares = 0;

    int m_state;
    int m_a;
    int m_b;
    int m_op;
    bit m_bseen;

    logic [3*WB+3:0] dut_vec;

    always #5 clk = ~clk;

    calc_input_ctrl #(.MAX_DIGITS(MAXD), .W(WB)) dut (
        .clk        (clk),
        .clear      (clear),
        .key_code   (key_code),
        .op_a       (op_a),
        .op_b       (op_b),
        .opcode     (opcode),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .disp_value (disp_value),
        .busy       (busy)
    );

    assign dut_vec = {op_a, op_b, opcode, req_valid, busy, disp_value};

    // ---------------- reference model ----------------
    // An operand of n significant digits is below 10^n, so another digit fits
    // exactly when the value is below 10^(MAXD-1).
    function automatic int m_acc(input int v, input int d);
        return (v < LIMIT) ? v * 10 + d : v;
    endfunction

    function automatic logic [3*WB+3:0] m_vec();
        int disp;
        disp = (m_state == M_A) ? m_a : m_b;
        return {WB'(m_a), WB'(m_b), 2'(m_op), m_state == M_REQ, m_state == M_REQ, WB'(disp)};
    endfunction

    task automatic m_reset();
        m_state = M_A; m_a = 0; m_b = 0; m_op = 0; m_bseen = 0;
    endtask

    task automatic m_event(input int k);
        if (k > 14) return;
        case (m_state)
            M_A: begin
                if (k < 10) m_a = m_acc(m_a, k);
                else if (k < 14) begin m_op = k - 10; m_b = 0; m_bseen = 0; m_state = M_B; end
            end
            M_B: begin
                if (k < 10) begin m_b = m_acc(m_b, k); m_bseen = 1; end
                else if (k < 14) begin if (!m_bseen) m_op = k - 10; end
                else if (m_bseen) m_state = M_REQ;
            end
            M_DONE: begin
                if (k < 10) begin m_a = k; m_b = 0; m_bseen = 0; m_state = M_A; end
            end
            default: ;
        endcase
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        m_reset();
    endtask

    task automatic press(input int k);
        key_code = 5'(k);
        tick();
        m_event(k);
        key_code = 5'd16;
        tick();
    endtask

    task automatic ready_pulse();
        req_ready = 1'b1;
        tick();
        if (m_state == M_REQ) m_state = M_DONE;
        req_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        key_code = 5'd3;
        req_ready = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        key_code = 5'd16;
        req_ready = 1'b0;
        m_reset();
        vectors++;
        if (dut_vec !== '0) begin
            miscompares++;
            $display("FAIL reset: got %h want 0", dut_vec);
        end
        tick();
        vectors++;
        if (dut_vec !== m_vec()) begin
            miscompares++;
            $display("FAIL reset_key_discard: got %h want %h", dut_vec, m_vec());
        end
    endtask

    task automatic test_request();
        do_clear();
        req_ready = 1'b0;
        press(1); press(2); press(10); press(3); press(14);
        vectors++;
        if ({op_a, op_b, opcode, req_valid, busy} !== {14'd12, 14'd3, 2'b00, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL request_issue: got a=%0d b=%0d op=%0d v=%0d busy=%0d want a=12 b=3 op=0 v=1 busy=1",
                     op_a, op_b, opcode, req_valid, busy);
        end
        // Hold 20 cycles with key traffic that must be ignored.
        for (int i = 0; i < 10; i++) begin
            press(int'($urandom_range(0, 15)));
            vectors++;
            if (dut_vec !== m_vec() || dut_vec !== {14'd12, 14'd3, 2'b00, 1'b1, 1'b1, 14'd3}) begin
                miscompares++;
                $display("FAIL request_hold[%0d]: got %h want %h", i, dut_vec, m_vec());
            end
        end
    endtask

    task automatic test_handshake();
        ready_pulse();
        vectors++;
        if (req_valid !== 1'b0 || busy !== 1'b0 || dut_vec !== m_vec()) begin
            miscompares++;
            $display("FAIL handshake_done: got v=%0d busy=%0d vec=%h want %h", req_valid, busy, dut_vec, m_vec());
        end
        press(7);
        vectors++;
        if ({op_a, op_b, disp_value, req_valid} !== {14'd7, 14'd0, 14'd7, 1'b0} || dut_vec !== m_vec()) begin
            miscompares++;
            $display("FAIL handshake_new_digit: got a=%0d b=%0d disp=%0d want a=7 b=0 disp=7", op_a, op_b, disp_value);
        end
        // req_ready outside REQ has no effect
        ready_pulse();
        tick();
        vectors++;
        if (dut_vec !== m_vec()) begin
            miscompares++;
            $display("FAIL ready_outside_req: got %h want %h", dut_vec, m_vec());
        end
    endtask

    task automatic test_max_digits();
        do_clear();
        for (int i = 0; i < 5; i++) press(9);
        vectors++;
        if (op_a !== 14'd9999 || disp_value !== 14'd9999 || dut_vec !== m_vec()) begin
            miscompares++;
            $display("FAIL max_digits: got a=%0d disp=%0d want 9999", op_a, disp_value);
        end
        do_clear();
        key_code = 5'd5;
        for (int i = 0; i < 100; i++) tick();
        m_event(5);
        key_code = 5'd16;
        tick();
        vectors++;
        if (op_a !== 14'd5 || dut_vec !== m_vec()) begin
            miscompares++;
            $display("FAIL held_key: got a=%0d want 5", op_a);
        end
        // Leading zeros do not count toward the digit limit.
        do_clear();
        press(0); press(0); press(1); press(0); press(0); press(0); press(7);
        vectors++;
        if (op_a !== 14'd1000 || dut_vec !== m_vec()) begin
            miscompares++;
            $display("FAIL leading_zeros: got a=%0d want 1000", op_a);
        end
    endtask

    task automatic test_opcode();
        do_clear();
        press(14);
        vectors++;
        if (dut_vec !== '0) begin
            miscompares++;
            $display("FAIL eq_in_enter_a: got %h want 0", dut_vec);
        end
        press(4); press(12); press(11);
        press(14);
        vectors++;
        if (req_valid !== 1'b0 || opcode !== 2'b01 || dut_vec !== m_vec()) begin
            miscompares++;
            $display("FAIL eq_without_b: got v=%0d op=%0d want v=0 op=1", req_valid, opcode);
        end
        press(2); press(13); press(14);
        vectors++;
        if ({opcode, op_a, op_b, req_valid} !== {2'b01, 14'd4, 14'd2, 1'b1} || dut_vec !== m_vec()) begin
            miscompares++;
            $display("FAIL opcode_replace: got op=%0d a=%0d b=%0d v=%0d want op=1 a=4 b=2 v=1",
                     opcode, op_a, op_b, req_valid);
        end
        do_clear();
        press(5); press(10); press(0); press(14);
        vectors++;
        if ({op_a, op_b, req_valid} !== {14'd5, 14'd0, 1'b1} || dut_vec !== m_vec()) begin
            miscompares++;
            $display("FAIL zero_operand_b: got a=%0d b=%0d v=%0d want a=5 b=0 v=1", op_a, op_b, req_valid);
        end
    endtask

    task automatic test_clear_in_req();
        do_clear();
        press(8); press(11); press(6); press(14);
        req_ready = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        req_ready = 1'b0;
        m_reset();
        vectors++;
        if (dut_vec !== '0) begin
            miscompares++;
            $display("FAIL clear_in_req: got %h want 0", dut_vec);
        end
        press(3);
        vectors++;
        if (op_a !== 14'd3 || disp_value !== 14'd3 || dut_vec !== m_vec()) begin
            miscompares++;
            $display("FAIL after_clear_enter_a: got a=%0d disp=%0d want 3", op_a, disp_value);
        end
    endtask

    task automatic test_back_to_back();
        int r;
        int k1;
        int k2;
        do_clear();
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6) begin
                k1 = int'($urandom_range(0, 15));
                key_code = 5'(k1);
                tick();
                m_event(k1);
                vectors++;
                if (dut_vec !== m_vec()) begin
                    miscompares++;
                    $display("FAIL rand_event[%0d] key=%0d: got %h want %h", i, k1, dut_vec, m_vec());
                end
                key_code = 5'd16;
                tick();
            end else if (r < 8) begin
                // Roll from one key straight to another: only the first counts.
                k1 = int'($urandom_range(0, 15));
                k2 = int'($urandom_range(0, 15));
                key_code = 5'(k1);
                tick();
                m_event(k1);
                key_code = 5'(k2);
                tick();
                tick();
                key_code = 5'd16;
                tick();
                vectors++;
                if (dut_vec !== m_vec()) begin
                    miscompares++;
                    $display("FAIL rand_rollover[%0d] keys=%0d,%0d: got %h want %h", i, k1, k2, dut_vec, m_vec());
                end
            end else begin
                ready_pulse();
                vectors++;
                if (dut_vec !== m_vec()) begin
                    miscompares++;
                    $display("FAIL rand_ready[%0d]: got %h want %h", i, dut_vec, m_vec());
                end
            end
        end
    endtask

    initial begin
        clear     = 1'b0;
        key_code  = 5'd16;
        req_ready = 1'b0;
        m_reset();
        tick();
        test_reset();
        test_request();
        test_handshake();
        test_max_digits();
        test_opcode();
        test_clear_in_req();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/calc_input_ctrl.md
CALC_INPUT_CTRL -- requirements
Module: calc_input_ctrl

Interface
REQ-001 Parameter MAX_DIGITS: default 4; maximum decimal digits accepted per operand.
REQ-002 Parameter W: default 14; operand width in bits; SHALL hold 10^MAX_DIGITS-1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 clear  input  1  reset; synchronous, active-high.
REQ-005 key_code  input  5  debounced key from keyboard driver: 0-9 digit, 10 '+', 11 '-', 12 '*', 13 '/', 14 '=', 15 unused, 16 no key.
REQ-006 op_a  output  W  first operand to the ALU stage.
REQ-007 op_b  output  W  second operand to the ALU stage.
REQ-008 opcode  output  2  operator: 00 '+', 01 '-', 10 '*', 11 '/'.
REQ-009 req_valid  output  1  operands and opcode valid for the ALU stage.
REQ-010 req_ready  input  1  ALU stage accepts the request.
REQ-011 disp_value  output  W  operand currently being entered, for the display.
REQ-012 busy  output  1  high in REQ state.

Function
REQ-013 key_code SHALL be registered into key_prev every cycle; key_prev resets to 16.
REQ-014 Key event SHALL be detected when key_code != 16 and key_prev == 16; a held key yields exactly one event; code 15 events are discarded.
REQ-015 All responses to an event SHALL be visible on outputs one cycle after the event cycle.
REQ-016 States: ENTER_A, ENTER_B, REQ, DONE; encoded in 2 bits.
REQ-017 Digit accumulation SHALL be operand <= operand*10 + digit, computed in W bits, with a per-operand digit counter.
REQ-018 Leading zeros (digit 0 with operand 0) SHALL NOT increment the digit counter.
REQ-019 A digit event with counter == MAX_DIGITS SHALL be ignored; operand unchanged; no wrap-around.
REQ-020 ENTER_A: digit -> accumulate into op_a; operator -> latch opcode, clear op_b and its counter, go to ENTER_B (op_a 0 is allowed); '=' -> ignored.
REQ-021 ENTER_B: digit -> accumulate into op_b; operator with zero op_b digits entered -> replace opcode and stay; operator after op_b digits -> ignored; '=' with at least one op_b digit event -> go to REQ; '=' with no op_b digit events -> ignored.
REQ-022 REQ: req_valid = 1; op_a, op_b and opcode SHALL be held stable; all key events ignored; on req_valid && req_ready in the same cycle -> DONE, with req_valid low on the next cycle.
REQ-023 req_valid SHALL NOT depend combinationally on req_ready; req_ready outside REQ SHALL be ignored.
REQ-024 DONE: digit -> clear op_a, op_b, and the counters, accumulate the digit into op_a, go to ENTER_A; operator or '=' -> ignored.
REQ-025 disp_value SHALL be op_a in ENTER_A, and op_b in ENTER_B, REQ and DONE.
REQ-026 busy SHALL equal (state == REQ); req_valid SHALL equal (state == REQ).
REQ-027 An event in the same cycle as clear SHALL be discarded; clear has priority.

Reset
REQ-028 On clear: state = ENTER_A; op_a = op_b = disp_value = 0; opcode = 00; counters = 0; req_valid = busy = 0; key_prev = 16.
REQ-029 clear asserted in REQ SHALL drop req_valid on the next cycle, even if req_ready is high in that cycle.

Verification
REQ-030 Keys 1,2,'+',3,'=' with each press separated by code 16, and req_ready = 0 -> req_valid = 1, op_a = 12, op_b = 3, opcode = 00, held stable for 20 cycles.
REQ-031 While req_valid is high, raise req_ready for 1 cycle -> req_valid = 0 on the next cycle, busy = 0; then key 7 -> state ENTER_A, op_a = 7, op_b = 0.
REQ-032 Keys 9,9,9,9,9 -> op_a = 9999, disp_value = 9999 (fifth digit ignored); key 5 held for 100 cycles from reset -> op_a = 5, single event only.
REQ-033 Keys 4,'*','-',2,'=' -> opcode = 01, op_a = 4, op_b = 2; '=' pressed in ENTER_A -> no state change.
REQ-034 clear pulsed while req_valid = 1 and req_ready = 1 -> no handshake; next cycle: all outputs 0, state ENTER_A.
